// File: rtl/prm_edge_pkg.sv
// Shared constants, FSM state encoding and helpers for the PRM edge scan controller.
package prm_edge_pkg;
    localparam int unsigned CODE_W     = 15;
    localparam int unsigned DEF_WORD_W = 32;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_e;

    // chk_code bit positions of the checker letters: bit0 = A ... bit14 = O
    localparam int unsigned CHK_BIT_A = 0;
    localparam int unsigned CHK_BIT_B = 1;
    localparam int unsigned CHK_BIT_C = 2;
    localparam int unsigned CHK_BIT_D = 3;
    localparam int unsigned CHK_BIT_E = 4;
    localparam int unsigned CHK_BIT_F = 5;
    localparam int unsigned CHK_BIT_G = 6;
    localparam int unsigned CHK_BIT_H = 7;
    localparam int unsigned CHK_BIT_I = 8;
    localparam int unsigned CHK_BIT_J = 9;
    localparam int unsigned CHK_BIT_K = 10;
    localparam int unsigned CHK_BIT_L = 11;
    localparam int unsigned CHK_BIT_M = 12;
    localparam int unsigned CHK_BIT_N = 13;
    localparam int unsigned CHK_BIT_O = 14;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/prm_edge_scan_ctrl_if.sv
// Result-word valid/ready stream from the edge scan controller to the roadmap builder.
interface prm_edge_scan_ctrl_if #(
    parameter int unsigned WORD_W = prm_edge_pkg::DEF_WORD_W
);
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/prm_edge_pack.sv
// Packs sampled edge_mask bits LSB-first into words and holds them in a valid/ready output register.
module prm_edge_pack #(
    parameter int unsigned WORD_W = prm_edge_pkg::DEF_WORD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic                    sample_bit,
    input  logic                    sample_last,
    output logic                    stall,
    prm_edge_scan_ctrl_if.master    m
);
    localparam int unsigned IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] acc_q, acc_d, data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              full_q, full_d, full_last_q, full_last_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic              handoff, take;

    // A completed word waits one cycle in the accumulator; the next code is
    // sampled into a fresh accumulator in the same cycle it hands off.
    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        full_d      = full_q;
        full_last_d = full_last_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;

        stall   = full_q && valid_q && !m.m_ready;
        handoff = full_q && !stall;
        take    = sample_en && !stall;

        if (handoff) begin
            data_d  = acc_q;
            valid_d = 1'b1;
            last_d  = full_last_q;
            acc_d   = '0;
            full_d  = 1'b0;
        end else if (valid_q && m.m_ready) begin
            valid_d = 1'b0;
        end

        if (take) begin
            acc_d[idx_q] = sample_bit;
            if (idx_q == IDX_W'(WORD_W - 1) || sample_last) begin
                full_d      = 1'b1;
                full_last_d = sample_last;
                idx_d       = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            idx_q       <= '0;
            full_q      <= 1'b0;
            full_last_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            full_q      <= full_d;
            full_last_q <= full_last_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_last  = last_q;
endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Scans a range of edge codes through the PRM obstacle checker and streams packed results.
module prm_edge_scan_ctrl
    import prm_edge_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CODE_W-1:0]    code_base,
    input  logic [CNT_W-1:0]     code_count,
    output logic                 busy,
    output logic [CODE_W-1:0]    chk_code,
    output logic                 chk_vld,
    input  logic                 edge_mask,
    prm_edge_scan_ctrl_if.master m,
    output logic [CNT_W-1:0]     hit_count,
    output logic                 done
);
    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  rem_q, rem_d, hit_q, hit_d;
    logic              vld_q, vld_d, busy_q, busy_d, done_q, done_d;
    logic              stall, sample_en, sample_last;

    assign sample_en   = (state_q == S_SCAN) && vld_q;
    assign sample_last = (rem_q == CNT_W'(1));

    prm_edge_pack #(.WORD_W(WORD_W)) u_pack (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .sample_bit  (edge_mask),
        .sample_last (sample_last),
        .stall       (stall),
        .m           (m)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rem_d   = rem_q;
        hit_d   = hit_q;
        vld_d   = vld_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    hit_d = '0;
                    rem_d = code_count;
                    if (code_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                        code_d  = code_base;
                        vld_d   = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (vld_q && !stall) begin
                    if (edge_mask) hit_d = sat_inc(hit_q);
                    code_d = code_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (sample_last) begin
                        vld_d   = 1'b0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (m.m_valid && m.m_ready && m.m_last) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            rem_q   <= '0;
            hit_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rem_q   <= rem_d;
            hit_q   <= hit_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign chk_code  = code_q;
    assign chk_vld   = vld_q;
    assign hit_count = hit_q;
    assign done      = done_q;
endmodule
